// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between the scalar pipe and the vector unit.
// Optional perf counters are built in when ALU_ARB_PERF_EN is defined.
module alu_arbiter #(
    parameter int XLEN      = 32,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0]      req_lock,
    input  logic [5:0]      req_ctrl0,
    input  logic [5:0]      req_ctrl1,
    input  logic [XLEN-1:0] req_a0,
    input  logic [XLEN-1:0] req_a1,
    input  logic [XLEN-1:0] req_b0,
    input  logic [XLEN-1:0] req_b1,
    output logic [5:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [XLEN-1:0] rsp_data0,
    output logic [XLEN-1:0] rsp_data1,
    output logic            busy
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]     perf_conflict,
    output logic [15:0]     perf_forced
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    logic [1:0] state;
    logic       rr_ptr;
    logic [3:0] burst_cnt;
    logic       iss_port;

    logic       wb_fire;
    logic       iss_free;
    logic [1:0] elig;
    logic       hold0;
    logic       hold1;
    logic       held;
    logic       hp;
    logic       op;
    logic       at_max;
    logic [1:0] grant;
    logic       nxt_rr;
    logic [3:0] nxt_burst;
    logic [1:0] nxt_state;
    logic       accept;
    logic       acc_port;

    // The issue register drains into its buffer unless that buffer is full and held.
    assign wb_fire  = busy & (~rsp_valid[iss_port] | rsp_ready[iss_port]);
    assign iss_free = ~busy | wb_fire;

    assign elig[0] = req_valid[0] & (~rsp_valid[0] | rsp_ready[0]) & iss_free;
    assign elig[1] = req_valid[1] & (~rsp_valid[1] | rsp_ready[1]) & iss_free;

    assign hold0  = (state == GRANT0) & req_lock[0] & elig[0];
    assign hold1  = (state == GRANT1) & req_lock[1] & elig[1];
    assign held   = hold0 | hold1;
    assign hp     = hold1;
    assign op     = ~hp;
    assign at_max = burst_cnt >= BURST_LAST;

    always_comb begin
        grant     = 2'b00;
        nxt_rr    = rr_ptr;
        nxt_burst = 4'd0;
        if (held && !at_max) begin
            grant[hp] = 1'b1;
            nxt_burst = burst_cnt + 4'd1;
        end else if (held) begin
            if (elig[op]) begin
                grant[op] = 1'b1;
                nxt_rr    = hp;
            end else begin
                grant[hp] = 1'b1;
            end
        end else if (&elig) begin
            grant[rr_ptr] = 1'b1;
            nxt_rr        = ~rr_ptr;
        end else begin
            grant = elig;
        end
    end

    always_comb begin
        nxt_state = IDLE;
        unique case (1'b1)
            grant[0]: nxt_state = GRANT0;
            grant[1]: nxt_state = GRANT1;
            default:  nxt_state = IDLE;
        endcase
    end

    assign req_ready = grant & {2{rst_n}};
    assign accept    = |req_ready;
    assign acc_port  = req_ready[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            burst_cnt <= 4'd0;
            busy      <= 1'b0;
            iss_port  <= 1'b0;
            alu_ctrl  <= 6'd0;
            alu_a     <= '0;
            alu_b     <= '0;
        end else begin
            state     <= nxt_state;
            rr_ptr    <= nxt_rr;
            burst_cnt <= nxt_burst;
            if (accept) begin
                busy     <= 1'b1;
                iss_port <= acc_port;
                alu_ctrl <= acc_port ? req_ctrl1 : req_ctrl0;
                alu_a    <= acc_port ? req_a1 : req_a0;
                alu_b    <= acc_port ? req_b1 : req_b0;
            end else if (wb_fire) begin
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 2'b00;
            rsp_data0 <= '0;
            rsp_data1 <= '0;
        end else begin
            if (wb_fire && !iss_port) begin
                rsp_valid[0] <= 1'b1;
                rsp_data0    <= alu_result;
            end else if (rsp_ready[0]) begin
                rsp_valid[0] <= 1'b0;
            end
            if (wb_fire && iss_port) begin
                rsp_valid[1] <= 1'b1;
                rsp_data1    <= alu_result;
            end else if (rsp_ready[1]) begin
                rsp_valid[1] <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic forced;
    assign forced = held & at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_conflict <= 16'd0;
            perf_forced   <= 16'd0;
        end else begin
            if ((&elig) && perf_conflict != 16'hFFFF)
                perf_conflict <= perf_conflict + 16'd1;
            if (forced && perf_forced != 16'hFFFF)
                perf_forced <= perf_forced + 16'd1;
        end
    end
`endif

endmodule
